wb_region_decoder: RTL



---
 rtl/wb_region_decoder.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_region_decoder.sv
// Single-master classic Wishbone decoder/multiplexer.
// Routes each master cycle to the lowest-numbered region whose address prefix
// matches. Every response to the master is registered. Unmapped addresses get
// an error response, and a slave that never answers is aborted after
// TIMEOUT_CYCLES. Error statistics are kept for firmware to read.
module wb_region_decoder #(
   parameter int                         NUM_SLAVES         = 4,
   // Slot i sits at bits [32i+31:32i], so slot 0 is the rightmost element.
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE         = {32'hF8000000, 32'h80000000,
                                                               32'hF0000800, 32'hF0000000},
   parameter logic [NUM_SLAVES*8-1:0]    SLAVE_AW           = {8'd14, 8'd27, 8'd11, 8'd11},
   parameter int                         TIMEOUT_CYCLES     = 255,
   parameter logic [31:0]                DEFAULT_READ_VALUE = 32'hBADFABAC
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [31:0]                  m_adr_i,
   input  logic [31:0]                  m_dat_i,
   input  logic [3:0]                   m_sel_i,
   input  logic                         m_we_i,
   input  logic                         m_stb_i,
   input  logic                         m_cyc_i,
   output logic [31:0]                  m_dat_o,
   output logic                         m_ack_o,
   output logic                         m_err_o,
   output logic [31:0]                  s_adr_o,
   output logic [31:0]                  s_dat_o,
   output logic [3:0]                   s_sel_o,
   output logic [NUM_SLAVES-1:0]        s_we_o,
   output logic [NUM_SLAVES-1:0]        s_stb_o,
   output logic [NUM_SLAVES-1:0]        s_cyc_o,
   input  logic [NUM_SLAVES*32-1:0]     s_dat_i,
   input  logic [NUM_SLAVES-1:0]        s_ack_i,
   input  logic [NUM_SLAVES-1:0]        s_err_i,
   input  logic                         clr_err_i,
   output logic [15:0]                  err_count_o,
   output logic [31:0]                  last_err_adr_o,
   output logic                         timeout_o
);

   localparam int         IDXW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   state_t                 r_state;
   state_t                 w_nextState;

   logic [31:0]            r_adr;
   logic [31:0]            r_dat;
   logic [3:0]             r_sel;
   logic                   r_we;
   logic [IDXW-1:0]        r_idx;
   logic [15:0]            r_timer;

   logic [31:0]            r_mDat;
   logic                   r_mAck;
   logic                   r_mErr;

   logic [15:0]            r_errCount;
   logic [31:0]            r_lastErrAdr;
   logic                   r_timeout;

   logic                   w_hit;
   logic [IDXW-1:0]        w_hitIdx;
   logic [31:0]            w_mask;

   logic                   w_selAck;
   logic                   w_selErr;
   logic [31:0]            w_selDat;
   logic [NUM_SLAVES-1:0]  w_slaveEn;

   logic                   w_latch;
   logic                   w_respAck;
   logic                   w_respErr;
   logic [31:0]            w_respDat;
   logic                   w_timeoutEvt;
   logic [31:0]            w_errAdr;

   // Address decode: scan downwards so the lowest matching region wins.
   always_comb begin
      w_hit    = 1'b0;
      w_hitIdx = '0;
      w_mask   = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         w_mask = 32'hFFFF_FFFF << SLAVE_AW[8*i +: 8];
         if (((m_adr_i ^ SLAVE_BASE[32*i +: 32]) & w_mask) == 32'h0) begin
            w_hit    = 1'b1;
            w_hitIdx = IDXW'(i);
         end
      end
   end

   // Pick out the selected slave's response and build the one-hot slave enable.
   always_comb begin
      w_selAck  = 1'b0;
      w_selErr  = 1'b0;
      w_selDat  = '0;
      w_slaveEn = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_idx == IDXW'(i)) begin
            w_selAck     = s_ack_i[i];
            w_selErr     = s_err_i[i];
            w_selDat     = s_dat_i[32*i +: 32];
            w_slaveEn[i] = (r_state == ACTIVE);
         end
      end
   end

   // Next-state logic and the response that will be registered on entry to RESP.
   always_comb begin
      w_nextState  = r_state;
      w_latch      = 1'b0;
      w_respAck    = 1'b0;
      w_respErr    = 1'b0;
      w_respDat    = r_mDat;
      w_timeoutEvt = 1'b0;
      w_errAdr     = r_adr;
      case (r_state)
         IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               w_latch = 1'b1;
               if (w_hit) begin
                  w_nextState = ACTIVE;
               end else begin
                  w_nextState = RESP;
                  w_respErr   = 1'b1;
                  w_respDat   = DEFAULT_READ_VALUE;
                  w_errAdr    = m_adr_i;
               end
            end
         end
         ACTIVE: begin
            if (!m_cyc_i) begin
               w_nextState = IDLE;
            end else if (w_selErr) begin
               w_nextState = RESP;
               w_respErr   = 1'b1;
               w_respDat   = DEFAULT_READ_VALUE;
            end else if (w_selAck) begin
               w_nextState = RESP;
               w_respAck   = 1'b1;
               w_respDat   = w_selDat;
            end else if (r_timer == TO_LAST) begin
               w_nextState  = RESP;
               w_respErr    = 1'b1;
               w_respDat    = DEFAULT_READ_VALUE;
               w_timeoutEvt = 1'b1;
            end
         end
         RESP: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Capture the request when it is accepted; these are broadcast to every slave.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_adr <= '0;
         r_dat <= '0;
         r_sel <= '0;
         r_we  <= 1'b0;
         r_idx <= '0;
      end else if (w_latch) begin
         r_adr <= m_adr_i;
         r_dat <= m_dat_i;
         r_sel <= m_sel_i;
         r_we  <= m_we_i;
         r_idx <= w_hitIdx;
      end
   end

   // Count cycles spent waiting on the slave; restarted for every new request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_timer <= '0;
      end else if (w_latch) begin
         r_timer <= '0;
      end else if (r_state == ACTIVE) begin
         r_timer <= r_timer + 16'd1;
      end
   end

   // Master response registers; ack/err last one cycle, data holds until the next response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mAck <= 1'b0;
         r_mErr <= 1'b0;
         r_mDat <= '0;
      end else begin
         r_mAck <= w_respAck;
         r_mErr <= w_respErr;
         r_mDat <= w_respDat;
      end
   end

   // Error statistics; a clear that coincides with a new error leaves just that error counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_errCount   <= '0;
         r_lastErrAdr <= '0;
         r_timeout    <= 1'b0;
      end else if (w_respErr) begin
         r_lastErrAdr <= w_errAdr;
         if (clr_err_i) begin
            r_errCount <= 16'd1;
            r_timeout  <= w_timeoutEvt;
         end else begin
            if (r_errCount != 16'hFFFF) begin
               r_errCount <= r_errCount + 16'd1;
            end
            r_timeout <= r_timeout | w_timeoutEvt;
         end
      end else if (clr_err_i) begin
         r_errCount <= '0;
         r_timeout  <= 1'b0;
      end
   end

   assign m_dat_o        = r_mDat;
   assign m_ack_o        = r_mAck;
   assign m_err_o        = r_mErr;
   assign s_adr_o        = r_adr;
   assign s_dat_o        = r_dat;
   assign s_sel_o        = r_sel;
   assign s_cyc_o        = w_slaveEn;
   assign s_stb_o        = w_slaveEn;
   assign s_we_o         = w_slaveEn & {NUM_SLAVES{r_we}};
   assign err_count_o    = r_errCount;
   assign last_err_adr_o = r_lastErrAdr;
   assign timeout_o      = r_timeout;

endmodule
